// File: rtl/div_unit_pkg.sv
// Shared state encodings and control constants for the iterative divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ZERO = 2'b01,
    DIV_CALC = 2'b10,
    DIV_DONE = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivSigned         = 1'b1;
  localparam logic DivUnsigned       = 1'b0;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring step: shift {partial_rem, quot} left, trial-subtract the divisor.
module div_unit_step #(
  parameter int DW = 32
) (
  input  logic [2*DW:0] rem_quot_i,
  input  logic [DW-1:0] divisor_i,
  output logic [2*DW:0] rem_quot_o
);

  logic [2*DW+1:0] shifted;
  logic [DW:0]     diff;
  logic            ge;

  always_comb begin
    shifted    = {rem_quot_i, 1'b0};
    ge         = shifted[2*DW+1:DW] >= {2'b00, divisor_i};
    diff       = shifted[2*DW:DW] - {1'b0, divisor_i};
    rem_quot_o = ge ? {diff, shifted[DW-1:1], 1'b1} : shifted[2*DW:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU unit: quotient to LO, remainder to HI, stalls EX until done.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          signed_i,
  input  logic [DW-1:0] opdata1_i,
  input  logic [DW-1:0] opdata2_i,
  input  logic          cancel_i,
  output logic [DW-1:0] result_lo_o,
  output logic [DW-1:0] result_hi_o,
  output logic          ready_o,
  output logic          stall_o
);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*DW:0] work_q, work_d;
  logic [DW-1:0] divisor_q, divisor_d;
  logic          neg_quot_q, neg_quot_d;
  logic          neg_rem_q, neg_rem_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] lo_q, lo_d;
  logic [DW-1:0] hi_q, hi_d;

  logic [2*DW:0] step_out;
  logic [DW-1:0] op1_abs, op2_abs;
  logic          is_signed;

  div_unit_step #(.DW(DW)) u_step (
    .rem_quot_i (work_q),
    .divisor_i  (divisor_q),
    .rem_quot_o (step_out)
  );

  always_comb begin
    is_signed = (signed_i == DivSigned);
    op1_abs   = (signed_i == DivUnsigned || !opdata1_i[DW-1]) ? opdata1_i : -opdata1_i;
    op2_abs   = (signed_i == DivUnsigned || !opdata2_i[DW-1]) ? opdata2_i : -opdata2_i;
  end

  assign stall_o = (state_q == DIV_IDLE && start_i == DivStart && !cancel_i) ||
                   (state_q == DIV_CALC) || (state_q == DIV_ZERO);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    ready_d    = ready_q;
    lo_d       = lo_q;
    hi_d       = hi_q;

    if (cancel_i) begin
      if (state_q != DIV_IDLE) begin
        state_d = DIV_IDLE;
        ready_d = DivResultNotReady;
        lo_d    = '0;
        hi_d    = '0;
      end
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (start_i == DivStart) begin
            // Divide-by-zero results are staged directly in the working register.
            if (opdata2_i == '0) begin
              state_d    = DIV_ZERO;
              work_d     = {1'b0, opdata1_i, {DW{1'b1}}};
              neg_quot_d = 1'b0;
              neg_rem_d  = 1'b0;
            end else begin
              state_d    = DIV_CALC;
              cnt_d      = '0;
              work_d     = {{(DW+1){1'b0}}, op1_abs};
              divisor_d  = op2_abs;
              neg_quot_d = is_signed && (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
              neg_rem_d  = is_signed && opdata1_i[DW-1];
            end
          end
        end
        DIV_ZERO: begin
          state_d = DIV_DONE;
        end
        DIV_CALC: begin
          work_d = step_out;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1)) begin
            state_d = DIV_DONE;
            cnt_d   = '0;
          end
        end
        DIV_DONE: begin
          if (start_i == DivStop) begin
            state_d = DIV_IDLE;
            ready_d = DivResultNotReady;
            lo_d    = '0;
            hi_d    = '0;
          end else begin
            ready_d = DivResultReady;
            lo_d    = neg_quot_q ? -work_q[DW-1:0] : work_q[DW-1:0];
            hi_d    = neg_rem_q ? -work_q[2*DW-1:DW] : work_q[2*DW-1:DW];
          end
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      ready_q    <= DivResultNotReady;
      lo_q       <= '0;
      hi_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      ready_q    <= ready_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
    end
  end

  assign result_lo_o = lo_q;
  assign result_hi_o = hi_q;
  assign ready_o     = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected {hi,lo} queued at issue, compared when ready_o rises.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sgn, cancel;
  logic [31:0] op_a, op_b;
  logic [31:0] lo, hi;
  logic        ready, stall;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  div_unit #(.DW(32), .CW(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .signed_i    (sgn),
    .opdata1_i   (op_a),
    .opdata2_i   (op_b),
    .cancel_i    (cancel),
    .result_lo_o (lo),
    .result_hi_o (hi),
    .ready_o     (ready),
    .stall_o     (stall)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] q, r;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (!s) begin
      q = x / y;
      r = x % y;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end
    return {r, q};
  endfunction

  // Drives a request and returns #1 after the accepting edge, with operands scrambled.
  task automatic start_op(input logic s, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    sgn   = s;
    op_a  = x;
    op_b  = y;
    #1 check_eq("stall_accept", {63'd0, stall}, 64'd1);
    @(posedge clk);
    #1;
    op_a = $urandom;
    op_b = $urandom;
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (ready) seen = 1'b1;
    end
    check_eq(tag, {63'd0, seen}, 64'd0);
  endtask

  task automatic run_op(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] exp;
    logic        seen;
    int          n;
    int          lat;
    lat = (y == 32'd0) ? 2 : 33;
    sb_q.push_back(model(s, x, y));
    start_op(s, x, y);
    check_eq("stall_busy", {63'd0, stall}, 64'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (ready) seen = 1'b1;
    end
    check_eq("ready_seen", {63'd0, seen}, 64'd1);
    check_eq("latency", 64'(n), 64'(lat));
    check_eq("stall_done", {63'd0, stall}, 64'd0);
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 64'd1, 64'd0);
      exp = '0;
    end else begin
      exp = sb_q.pop_front();
    end
    check_eq("lo", {32'd0, lo}, {32'd0, exp[31:0]});
    check_eq("hi", {32'd0, hi}, {32'd0, exp[63:32]});
    @(posedge clk);
    #1 check_eq("hold", {31'd0, ready, lo}, {31'd0, 1'b1, exp[31:0]});
    start = 1'b0;
    @(posedge clk);
    #1 check_eq("drop", {30'd0, ready, stall, lo | hi}, 64'd0);
  endtask

  logic        d_s[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] d_a[8]  = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000,
                           32'h0000_1234, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd5};
  logic [31:0] d_b[8]  = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                           32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF};

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    sgn    = 1'b0;
    cancel = 1'b0;
    op_a   = '0;
    op_b   = '0;
    repeat (3) @(posedge clk);
    #1 check_eq("reset", {30'd0, ready, stall, lo | hi}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_op(d_s[i], d_a[i], d_b[i]);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op(1'($urandom_range(0, 1)), ra, rb);
    end

    // Cancel in IDLE must block acceptance.
    @(negedge clk);
    start  = 1'b1;
    cancel = 1'b1;
    #1 check_eq("idle_cancel_stall", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1;
    start  = 1'b0;
    cancel = 1'b0;
    watch_quiet("idle_cancel_ready", 40);

    // Cancel mid-CALC.
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    cancel = 1'b1;
    start  = 1'b0;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check_eq("cancel_idle", {61'd0, ready, stall, |lo}, 64'd0);
    watch_quiet("cancel_ready", 40);
    run_op(1'b0, 32'd1000, 32'd3);

    // Reset mid-CALC.
    start_op(1'b1, -32'd12345, 32'd77);
    repeat (19) @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_calc", {30'd0, ready, stall, lo | hi}, 64'd0);
    watch_quiet("rst_ready", 40);
    run_op(1'b1, -32'd12345, 32'd77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit integer divider for MIPS DIV/DIVU, in the EX stage.
- Its results feed the HI/LO register pair: quotient goes to LO, remainder goes to HI.
- Runs radix-2 restoring division, one quotient bit per cycle.
- Holds the pipeline stalled via stall_o until results are ready.

Parameters:
- DW, 32, operand/result width; only 32 is supported.
- CW, 6, width of the iteration counter (must hold the value DW).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request a division; held high by EX until ready_o is seen.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- cancel_i  in  1  flush (exception/branch); aborts the operation in flight.
- result_lo_o  out  32  quotient → lo_i.
- result_hi_o  out  32  remainder → hi_i.
- ready_o  out  1  results valid; drives hi_we/lo_we in WB after pipelining.
- stall_o  out  1  stall request to the pipeline controller.

Behaviour:
- Reset and output defaults:
  - rst: state=IDLE, counter=0, working regs=0, result_lo_o=result_hi_o=0, ready_o=0.
  - Priority: rst > cancel_i > start_i.
- States:
  - IDLE, DIVZERO, CALC, DONE.
  - State encoding is 2 bits, defined as shared constants.
- IDLE:
  - If start_i=1 and cancel_i=0, latch the operands and signed_i.
  - Divisor==0 → DIVZERO; otherwise → CALC with counter=0.
  - Later operand changes are ignored until the next acceptance.
- Signed mode:
  - Work on absolute values.
  - Negate the quotient if the operand signs differ.
  - The remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF yields q=0x80000000, r=0 (32-bit truncation, no trap).
- CALC:
  - Per cycle: shift the 65-bit {partial_rem, quot} left by 1.
  - Trial-subtract the |divisor| (33-bit compare).
  - If the result is non-negative, keep the difference and set quot[0]=1.
  - counter++.
  - When counter reaches 31, the final step is taken and the state goes to DONE.
  - Exactly 32 CALC cycles.
- DIVZERO:
  - One cycle, then DONE.
  - Results: q=0xFFFFFFFF, r = the latched dividend (unsigned or signed alike).
- DONE:
  - ready_o=1; results are sign-corrected and held stable.
  - Stays in DONE while start_i=1.
  - Returns to IDLE on the first cycle start_i=0; ready_o then falls on the next edge.
- Result outputs: result_* are 0 whenever the state is not DONE.
- Latency, edge E0 = the accepting edge:
  - Nonzero divisor: ready_o is high after edge E0+33.
  - Zero divisor: ready_o is high after edge E0+2.
- stall_o (combinational): high when (IDLE & start_i & ~cancel_i) | CALC | DIVZERO; low in DONE.
- cancel_i:
  - In any non-IDLE state, the next state is IDLE.
  - ready_o stays 0; no writeback occurs.
  - In IDLE, cancel_i blocks acceptance.
- Reset mid-CALC: returns to IDLE at that edge; no ready pulse.
- Back-to-back operations:
  - A new operation is only accepted from IDLE.
  - Upstream must drop start_i for at least one cycle between operations.

Decomposition:
- defines.vh holds:
  - The state encodings DIV_IDLE, DIV_ZERO, DIV_CALC, DIV_DONE.
  - The DivStart/DivStop and DivResultReady/NotReady constants.
  - The signed/unsigned select values.
- No sub-module is required.
- An optional combinational div_step (shift + trial subtract, 65-bit in/out) is natural if the iteration is reused by a future radix-4 variant.

Test Plan:
- Basic unsigned divide:
  - Stimulus: DIVU 100/7, start held.
  - Response: stall_o high during CALC; ready_o at E0+33; lo=14, hi=2.
  - Drop start → IDLE next cycle.
- Signed, negative dividend:
  - Stimulus: DIV -7/2 (0xFFFFFFF9/0x00000002).
  - Response: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Signed, negative divisor:
  - Stimulus: DIV 7/-2.
  - Response: lo=0xFFFFFFFD, hi=0x00000001.
- Overflow case:
  - Stimulus: DIV 0x80000000/0xFFFFFFFF.
  - Response: lo=0x80000000, hi=0, no hang.
- Divide by zero:
  - Stimulus: DIVU 0x1234/0.
  - Response: ready_o at E0+2; lo=0xFFFFFFFF, hi=0x00001234.
- Cancel and reset mid-operation:
  - Stimulus: cancel_i pulse at CALC cycle 10.
  - Response: IDLE next edge; ready_o never rises; a new start two cycles later completes correctly.
  - Stimulus: rst at CALC cycle 20.
  - Response: all outputs 0 on the next cycle.
